// File: rtl/router_out_arbiter.sv
// Per-output-port round-robin arbiter for the 16x16 serial router: one owner per packet, then a turnaround gap.
// Optional forced release after MAX_HOLD owned cycles when ROUTER_ARB_TIMEOUT_EN is defined.
module router_out_arbiter #(
  parameter int NUM_IN     = 16,
  parameter int GAP_CYCLES = 1,
  parameter int MAX_HOLD   = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         req,
  input  logic [NUM_IN-1:0]         eop,
  output logic [NUM_IN-1:0]         grant,
  output logic [$clog2(NUM_IN)-1:0] grant_id,
  output logic                      grant_vld,
  output logic                      busy_n,
  output logic                      timeout_err
);

  localparam int ID_W = $clog2(NUM_IN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  if (NUM_IN < 2 || NUM_IN > 16 || GAP_CYCLES < 1 || GAP_CYCLES > 7 || MAX_HOLD < 2) begin : g_bad_param
    $error("router_out_arbiter: parameter out of legal range");
  end

  state_t            state_r, state_s;
  logic [ID_W-1:0]   ptr_r, ptr_s;
  logic [NUM_IN-1:0] grant_r, grant_s;
  logic [ID_W-1:0]   grant_id_r, grant_id_s;
  logic              grant_vld_r, grant_vld_s;
  logic              busy_n_r, busy_n_s;
  logic              timeout_r, timeout_s;
  logic [2:0]        gap_r, gap_s;
  logic [ID_W-1:0]   pick_id_s;
  logic              pick_vld_s;
  logic              release_s;
  logic              force_s;

`ifdef ROUTER_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  logic [HOLD_W-1:0] hold_r, hold_s;
  assign force_s = (hold_r == HOLD_W'(MAX_HOLD - 1));
`else
  assign force_s = 1'b0;
`endif

  // Owner's own eop ends the packet; dropping its req is an abort.
  assign release_s = eop[grant_id_r] | ~req[grant_id_r];

  // Round-robin pick: first requester at or after ptr, wrapping.
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            hit;
    pick_vld_s = 1'b0;
    pick_id_s  = {ID_W{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      idx        = ID_W'((int'(ptr_r) + k) % NUM_IN);
      hit        = req[idx] & ~pick_vld_s;
      pick_id_s  = hit ? idx : pick_id_s;
      pick_vld_s = pick_vld_s | req[idx];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    grant_s     = grant_r;
    grant_id_s  = grant_id_r;
    grant_vld_s = grant_vld_r;
    busy_n_s    = busy_n_r;
    gap_s       = gap_r;
    timeout_s   = 1'b0;
`ifdef ROUTER_ARB_TIMEOUT_EN
    hold_s      = hold_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) begin
          state_s     = ST_OWN;
          grant_s     = NUM_IN'(1'b1) << pick_id_s;
          grant_id_s  = pick_id_s;
          grant_vld_s = 1'b1;
          busy_n_s    = 1'b0;
`ifdef ROUTER_ARB_TIMEOUT_EN
          hold_s      = {HOLD_W{1'b0}};
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (release_s || force_s) begin
          state_s     = ST_GAP;
          grant_s     = {NUM_IN{1'b0}};
          grant_vld_s = 1'b0;
          busy_n_s    = 1'b1;
          ptr_s       = (grant_id_r == ID_W'(NUM_IN - 1)) ? {ID_W{1'b0}} : grant_id_r + ID_W'(1);
          gap_s       = 3'(GAP_CYCLES - 1);
          // A genuine release on the same edge wins and suppresses the error pulse.
          timeout_s   = force_s & ~release_s;
        end else begin
          state_s = ST_OWN;
`ifdef ROUTER_ARB_TIMEOUT_EN
          hold_s  = hold_r + HOLD_W'(1);
`endif
        end
      end
      ST_GAP: begin
        if (gap_r == 3'd0) begin
          state_s = ST_IDLE;
        end else begin
          gap_s = gap_r - 3'd1;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        grant_s     = {NUM_IN{1'b0}};
        grant_vld_s = 1'b0;
        busy_n_s    = 1'b1;
        gap_s       = 3'd0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {ID_W{1'b0}};
      grant_r     <= {NUM_IN{1'b0}};
      grant_id_r  <= {ID_W{1'b0}};
      grant_vld_r <= 1'b0;
      busy_n_r    <= 1'b1;
      timeout_r   <= 1'b0;
      gap_r       <= 3'd0;
`ifdef ROUTER_ARB_TIMEOUT_EN
      hold_r      <= {HOLD_W{1'b0}};
`endif
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      grant_r     <= grant_s;
      grant_id_r  <= grant_id_s;
      grant_vld_r <= grant_vld_s;
      busy_n_r    <= busy_n_s;
      timeout_r   <= timeout_s;
      gap_r       <= gap_s;
`ifdef ROUTER_ARB_TIMEOUT_EN
      hold_r      <= hold_s;
`endif
    end
  end

  assign grant       = grant_r;
  assign grant_id    = grant_id_r;
  assign grant_vld   = grant_vld_r;
  assign busy_n      = busy_n_r;
  assign timeout_err = timeout_r;

endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Per-output-port arbiter for the 16x16 serial router.
- Arbitrates among the NUM_IN input ports that request one output port. Grants exactly one owner and holds the grant until that owner's packet ends.
- Drives the output's busy_n toward the input drivers.
- Round-robin fairness, with a programmable turnaround gap between packets.
- One instance per output port; 16 instances in the router top.

Parameters:
NUM_IN, 16, number of requesting input ports; legal range 2..16.
GAP_CYCLES, 1, idle cycles between release and next grant; legal range 1..7.
MAX_HOLD, 1024, cycle limit for one grant (used only with the optional feature).

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  asynchronous reset, active-high.
req  input  NUM_IN  bit i high: input port i wants this output; level held for the whole packet.
eop  input  NUM_IN  bit i: 1-cycle pulse on input i's last data bit (frame_n deassert).
grant  output  NUM_IN  one-hot owner; all-zero when unowned.
grant_id  output  $clog2(NUM_IN)  encoded owner index; valid only while grant_vld=1.
grant_vld  output  1  high while the output is owned.
busy_n  output  1  active-low; low exactly while grant_vld=1.
timeout_err  output  1  1-cycle pulse on forced release (feature only; tied 0 otherwise).

Behaviour:
- Reset (asynchronous assert; deassert synchronous to clock):
  - state=IDLE, ptr=0, grant=0, grant_id=0, grant_vld=0, busy_n=1, timeout_err=0, gap counter=0, hold counter=0.
  - Reset asserted mid-packet drops the grant immediately, with no gap.
- State machine: IDLE -> OWN -> GAP -> IDLE.
- IDLE:
  - If req!=0, select the first set bit scanning ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1.
  - Next edge: grant/grant_id/grant_vld set, busy_n=0, state=OWN.
  - Latency: req sampled at edge N -> grant visible after edge N+1.
  - If req==0, stay in IDLE; outputs unchanged.
- OWN:
  - Release when eop[grant_id]=1, or when req[grant_id]=0 (abort).
  - On release edge: grant=0, grant_vld=0, busy_n=1, ptr=(grant_id+1) mod NUM_IN, gap counter=GAP_CYCLES-1, state=GAP.
  - eop or req from non-owners is ignored.
  - Requests raised during OWN stay pending.
- GAP:
  - Count down; all outputs deasserted.
  - When counter==0, go to IDLE; arbitration happens in IDLE on the following edge.
  - Minimum owner-to-owner spacing is therefore GAP_CYCLES+1 cycles with grant_vld=0.
- Pointer wrap: owner NUM_IN-1 -> ptr=0.
- Simultaneous events:
  - eop and req drop together: a single release.
  - eop with the owner's req still high: release. The same input must win arbitration again and gets lowest priority next round.
- Single requester: re-granted every GAP_CYCLES+2 cycles per packet; no starvation.
- With all NUM_IN requesting continuously, each input gets one grant per NUM_IN packets, in index order from ptr.
- grant is always one-hot or zero; grant_id==index of the grant bit.

Optional Feature:
- Macro: ROUTER_ARB_TIMEOUT_EN.
- Defined:
  - Hold counter clears on grant and increments each OWN cycle.
  - If it reaches MAX_HOLD-1 without a release, force a release on the next edge: identical to a normal release (ptr advance, GAP), plus timeout_err=1 for that one cycle.
  - A normal release on the same edge takes precedence; no timeout_err.
- Not defined: no hold counter; timeout_err constant 0; MAX_HOLD unused.

Test Plan:
- Reset then req=16'h0000 for 20 cycles -> grant=0, grant_vld=0, busy_n=1 throughout.
- req=16'h0020 at edge 5 -> grant=16'h0020, grant_id=5, busy_n=0 after edge 6.
  - eop[5] pulse at edge 40 -> grant=0 after edge 41; ptr=6; with GAP_CYCLES=1, if req[5] still high, re-grant after edge 43.
- req=16'hFFFF continuously, eop pulses to each owner -> grant_id sequence 0,1,2,...,15,0.
- Owner 3 with ptr=4, req=16'h0009 -> next grant to 0 (wrap past 15); then 3.
- During OWN by 7: eop[2] pulse -> ignored; req[7] drops -> release next edge, no eop needed.
- ROUTER_ARB_TIMEOUT_EN, MAX_HOLD=8: owner 1 never sends eop -> forced release after 8 OWN cycles, timeout_err one pulse, next grant to the next requester above 1.
